// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle core: turns control-unit strobes into a registered
// ready-handshake bus transaction, with byte lanes, load extension, IR and MDR. Option: MEM_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memory_read,
  input  logic                  memory_write,
  input  logic                  lorD,
  input  logic                  ir_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ready,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_reg, state_next;

  logic                  req_active;
  logic                  is_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            lo;
  logic                  acc_half;
  logic                  acc_word;
  logic                  misalign_hit;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  // Per-transaction context, latched when the request is accepted in IDLE.
  logic       fetch_reg;
  logic       write_reg;
  logic       irw_reg;
  logic [2:0] f3_reg;
  logic [1:0] lo_reg;

  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_value;

  assign req_active = memory_read | memory_write;
  assign is_write   = memory_write;
  assign addr       = lorD ? alu_out : pc;
  assign lo         = addr[1:0];
  assign stall      = req_active && (state_reg != DONE);
  assign bus_req    = (state_reg == REQ);

  // Store funct3 101/11x fall back to a full word, while load 101 is LHU.
  always_comb begin
    acc_half = is_write ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
    acc_word = !lorD || (is_write ? (funct3[2] | funct3[1]) : funct3[1]);
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misalign_hit = 1'b0;
    if (acc_word)
      misalign_hit = (lo != 2'b00);
    else if (acc_half)
      misalign_hit = lo[0];
  end
`else
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    if (lorD && is_write && !acc_word) begin
      if (acc_half) begin
        be_next    = 4'b0011 << {lo[1], 1'b0};
        wdata_next = {2{store_data[15:0]}};
      end else begin
        be_next    = 4'b0001 << lo;
        wdata_next = {4{store_data[7:0]}};
      end
    end
  end

  always_comb begin
    shifted  = bus_rdata >> {lo_reg, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lo_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_reg)
      3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_value = {24'd0, byte_sel};
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_value = {16'd0, half_sel};
      default: load_value = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_active) state_next = misalign_hit ? DONE : REQ;
      REQ:     if (bus_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_be     <= 4'b0000;
      instr      <= 32'h0000_0013;
      mdr        <= '0;
      misaligned <= 1'b0;
      fetch_reg  <= 1'b0;
      write_reg  <= 1'b0;
      irw_reg    <= 1'b0;
      f3_reg     <= 3'b000;
      lo_reg     <= 2'b00;
    end else begin
      misaligned <= (state_reg == IDLE) && req_active && misalign_hit;
      if (state_reg == IDLE && req_active && !misalign_hit) begin
        bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
        bus_we    <= is_write;
        bus_be    <= be_next;
        bus_wdata <= wdata_next;
        fetch_reg <= !lorD;
        write_reg <= is_write;
        irw_reg   <= ir_write;
        f3_reg    <= funct3;
        lo_reg    <= lo;
      end
      // Capture on the edge leaving REQ, even if the request was withdrawn meanwhile.
      if (state_reg == REQ && bus_ready && !write_reg) begin
        if (fetch_reg) begin
          if (irw_reg)
            instr <= bus_rdata;
        end else begin
          mdr <= load_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, loads, stores, wait states, reset abort,
// and the misaligned-access path when MEM_MISALIGN_CHECK_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic        lorD = 1'b0;
  logic        ir_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] pc = 32'd0;
  logic [31:0] alu_out = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] mdr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        misaligned;

  int n_checks = 0;
  int n_fail = 0;

  // Results recorded by the access task.
  int          n_stall;
  int          n_req;
  logic        stable;
  logic        got_done;
  logic [31:0] s_addr;
  logic [3:0]  s_be;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [31:0] d_mdr;
  logic [31:0] d_instr;
  logic        d_mis;
  logic        d_req;
  logic        post_mis;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .memory_read(memory_read), .memory_write(memory_write),
    .lorD(lorD), .ir_write(ir_write), .funct3(funct3),
    .pc(pc), .alu_out(alu_out), .store_data(store_data),
    .stall(stall), .instr(instr), .mdr(mdr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .misaligned(misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge, plays the slave with `waits` not-ready REQ cycles,
  // runs until stall falls (DONE), records outputs, then drops the request and steps to IDLE.
  task automatic access(input logic rd, input logic wr, input logic ld, input logic irw,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdat, input int waits);
    int w;
    int guard;
    memory_read  = rd;
    memory_write = wr;
    lorD         = ld;
    ir_write     = irw;
    funct3       = f3;
    if (ld) alu_out = a;
    else    pc = a;
    store_data = sd;
    bus_rdata  = rdat;
    w          = waits;
    bus_ready  = (w == 0);
    n_stall = 0; n_req = 0; stable = 1'b1; got_done = 1'b0; guard = 0;
    while (!got_done && guard < 40) begin
      guard++;
      #1;
      if (!stall) begin
        got_done = 1'b1;
      end else begin
        n_stall++;
        if (bus_req) begin
          if (n_req == 0) begin
            s_addr = bus_addr; s_be = bus_be; s_we = bus_we; s_wdata = bus_wdata;
          end else if (bus_addr !== s_addr || bus_be !== s_be || bus_we !== s_we ||
                       bus_wdata !== s_wdata) begin
            stable = 1'b0;
          end
          n_req++;
        end
        @(negedge clk);
        if (n_req > 0 && w > 0) w--;
        bus_ready = (w == 0);
      end
    end
    check("access_done", 32'(got_done), 32'd1);
    d_mdr = mdr; d_instr = instr; d_mis = misaligned; d_req = bus_req;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    bus_ready    = 1'b0;
    @(negedge clk);
    post_mis = misaligned;
    $display("access rd=%0b wr=%0b lorD=%0b f3=%03b a=%h: stall=%0d req=%0d addr=%h be=%b mdr=%h instr=%h",
             rd, wr, ld, f3, a, n_stall, n_req, s_addr, s_be, d_mdr, d_instr);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_mdr", mdr, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);

    // Fetch with immediate ready
    access(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h104, 32'd0, 32'h0050_0093, 0);
    check("fetch_stall", n_stall, 2);
    check("fetch_req", n_req, 1);
    check("fetch_addr", s_addr, 32'h104);
    check("fetch_be", 32'(s_be), 32'hF);
    check("fetch_we", 32'(s_we), 32'd0);
    check("fetch_instr", d_instr, 32'h0050_0093);
    check("fetch_done_req", 32'(d_req), 32'd0);
    check("fetch_mis", 32'(d_mis), 32'd0);

    // LB / LBU from the top byte lane
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 32'h80FF_1234, 0);
    check("lb_addr", s_addr, 32'h200);
    check("lb_be", 32'(s_be), 32'hF);
    check("lb_mdr", d_mdr, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 32'h80FF_1234, 0);
    check("lbu_mdr", d_mdr, 32'h0000_0080);

    // SH upper half: read strobe also high, write must win
    access(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h302, 32'hDEAD_BEEF, 32'h1111_1111, 0);
    check("sh_we", 32'(s_we), 32'd1);
    check("sh_be", 32'(s_be), 32'hC);
    check("sh_wdata", s_wdata, 32'hBEEF_BEEF);
    check("sh_addr", s_addr, 32'h300);
    check("sh_mdr_kept", d_mdr, 32'h0000_0080);
    check("sh_instr_kept", d_instr, 32'h0050_0093);

    // SB lane 1
    access(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h301, 32'h1234_5678, 32'd0, 0);
    check("sb_be", 32'(s_be), 32'h2);
    check("sb_wdata", s_wdata, 32'h7878_7878);

    // LH / LHU upper half
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 32'h80FF_1234, 0);
    check("lh_mdr", d_mdr, 32'hFFFF_80FF);
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 32'h80FF_1234, 0);
    check("lhu_mdr", d_mdr, 32'h0000_80FF);

    // LW with three wait states
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h204, 32'd0, 32'hCAFE_F00D, 3);
    check("lw_wait_stall", n_stall, 5);
    check("lw_wait_req", n_req, 4);
    check("lw_wait_stable", 32'(stable), 32'd1);
    check("lw_wait_addr", s_addr, 32'h204);
    check("lw_wait_mdr", d_mdr, 32'hCAFE_F00D);

    // Fetch without ir_write leaves IR alone
    access(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h108, 32'd0, 32'hFFFF_FFFF, 0);
    check("fetch_noir_instr", d_instr, 32'h0050_0093);
    check("fetch_noir_addr", s_addr, 32'h108);

    // LW at an odd address
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h401, 32'd0, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_stall", n_stall, 1);
    check("mis_req", n_req, 0);
    check("mis_flag", 32'(d_mis), 32'd1);
    check("mis_mdr_kept", d_mdr, 32'hCAFE_F00D);
    check("mis_flag_pulse", 32'(post_mis), 32'd0);
`else
    check("odd_lw_stall", n_stall, 2);
    check("odd_lw_addr", s_addr, 32'h400);
    check("odd_lw_mis", 32'(d_mis), 32'd0);
    check("odd_lw_mdr", d_mdr, 32'h1122_3344);
`endif

    // Reset in the middle of REQ abandons the transaction
    memory_read = 1'b1; lorD = 1'b1; funct3 = 3'b010; alu_out = 32'h500;
    bus_ready = 1'b0; bus_rdata = 32'h9999_9999;
    @(negedge clk);
    check("abort_req_pre", 32'(bus_req), 32'd1);
    rst = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    check("abort_req", 32'(bus_req), 32'd0);
    check("abort_mdr", mdr, 32'd0);
    check("abort_instr", instr, 32'h0000_0013);
    check("abort_stall_idle", 32'(stall), 32'd1);
    rst = 1'b0;
    memory_read = 1'b0;
    bus_ready = 1'b0;
    @(negedge clk);
    check("abort_idle_req", 32'(bus_req), 32'd0);
    $display("reset abort checked");

    // Normal access after the abort
    access(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'h0000_0055, 0);
    check("post_rst_stall", n_stall, 2);
    check("post_rst_mdr", d_mdr, 32'h0000_0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side stage of the multicycle RISC-V core, sitting directly downstream of the control unit's `memory_read`, `memory_write`, `lorD` and `ir_write` outputs. It turns each one-state memory request into a registered bus transaction with a ready handshake and stalls the control unit until that transaction completes. It generates byte enables for stores, extracts and extends load data, and holds the instruction register and the memory data register (MDR).

## Interface
- `ADDR_WIDTH`, default 32: width of the bus address.
- `DATA_WIDTH`, default 32: width of the bus data. Only 32 is supported.
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memory_read`, `memory_write`, `lorD`, `ir_write`  in  1 each  control-unit request strobes, held while `stall`=1.
- `funct3`  in  3  width and sign selector for the access.
- `pc`  in  ADDR_WIDTH  fetch address, used when `lorD`=0.
- `alu_out`  in  ADDR_WIDTH  data address, used when `lorD`=1.
- `store_data`  in  32  rs2 value for stores.
- `stall`  out  1  holds the control unit in its current state.
- `instr`  out  32  instruction register.
- `mdr`  out  32  extended load result.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  ADDR_WIDTH  bus address, always word-aligned.
- `bus_wdata`  out  32  bus write data.
- `bus_be`  out  4  bus byte enables.
- `bus_ready`  in  1  slave completion for the current request.
- `bus_rdata`  in  32  read data, valid when `bus_ready`=1.
- `misaligned`  out  1  misaligned-access pulse (see Configuration).

## Operation
- A request is active when `memory_read`=1 or `memory_write`=1. If both are high, the access is a write and the read is ignored.
- The FSM has three states: IDLE, REQ, DONE.
  - IDLE, with a request active: register the address (`lorD` ? `alu_out` : `pc`), `bus_we`, `bus_be` and `bus_wdata`, then go to REQ.
  - REQ: hold `bus_req`=1. When `bus_ready`=1, capture the result and go to DONE.
  - DONE: spend one cycle, then go to IDLE unconditionally.
- `stall` = request active AND state != DONE. It is combinational.
- Instruction fetch (`lorD`=0): always a full word, `bus_be`=4'b1111. On completion, `instr` is loaded from `bus_rdata` only if `ir_write`=1.
- Data access (`lorD`=1), with a = address[1:0]:
  - Stores:
    - SB (`funct3`=000): `bus_be` = 4'b0001 << a; `bus_wdata` = the low byte replicated into all four lanes.
    - SH (`funct3`=001): `bus_be` = 4'b0011 << {a[1],1'b0}; `bus_wdata` = the low halfword replicated into both halves.
    - SW and any other `funct3`: `bus_be`=4'b1111.
  - Loads: `bus_be`=4'b1111; on completion `mdr` is loaded with the selected lane:
    - 000 LB: sign-extended byte.
    - 100 LBU: zero-extended byte.
    - 001 LH: sign-extended halfword.
    - 101 LHU: zero-extended halfword.
    - any other value: the full word.
- `bus_addr` = {address[ADDR_WIDTH-1:2], 2'b00}.
- Writes never change `mdr` or `instr`.
- If the request drops while in REQ, the transaction still completes and the captured data is written. DONE is still visited, and its result is ignored by the control unit.

## Timing
- Reset values:
  - FSM state: IDLE.
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0.
  - `instr`=32'h00000013 (NOP).
  - `mdr`=0.
  - `misaligned`=0.
- Bus rule: `bus_addr`, `bus_we`, `bus_wdata` and `bus_be` are stable while `bus_req`=1. `bus_req` stays high until `bus_ready` is sampled high, and drops in the cycle after that edge.
- Minimum latency, with `bus_ready` already high in the first REQ cycle:
  - request seen in IDLE at cycle 0;
  - REQ at cycle 1;
  - DONE at cycle 2 with `stall`=0.
  - `stall` is high for cycles 0 and 1.
- Each wait cycle of `bus_ready`=0 adds one cycle to the stall.
- `instr` and `mdr` update on the edge that leaves REQ, so they are valid during DONE.
- Back-to-back accesses: a new request can be accepted in the IDLE cycle that follows DONE.
- `rst` asserted mid-transaction abandons it at that edge: `bus_req` drops and no register captures data.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: the following accesses are misaligned:
  - LH, LHU or SH with address[0]=1;
  - a word access with address[1:0] != 0;
  - a fetch with `pc`[1:0] != 0.
  
  A misaligned access goes IDLE→DONE with no bus request. `misaligned` is high during that DONE cycle, and `instr` and `mdr` are unchanged.
- `MEM_MISALIGN_CHECK_EN` undefined: `misaligned` is tied to 0. Low address bits are ignored for word accesses, and halfword accesses use only address[1].

## Test plan
- Fetch: `pc`=0x104, `ir_write`=1, `bus_rdata`=0x00500093, `bus_ready` high immediately → `bus_addr`=0x104 and `bus_be`=4'b1111; `stall` high for 2 cycles; `instr`=0x00500093 in DONE.
- LB at `alu_out`=0x203, `bus_rdata`=0x80FF1234 → `bus_addr`=0x200; `mdr`=0xFFFFFF80. Repeat as LBU → `mdr`=0x00000080.
- SH at `alu_out`=0x302 with `store_data`=0xDEADBEEF → `bus_we`=1, `bus_be`=4'b1100, `bus_wdata`=0xBEEFBEEF; `mdr` unchanged.
- LW with `bus_ready` held low for 3 cycles → `bus_req` and address stable throughout; `stall` high for 5 cycles; `mdr` captured once.
- `rst` pulsed while in REQ → next cycle `bus_req`=0, state IDLE, `mdr`=0, `instr`=0x00000013.
- With `MEM_MISALIGN_CHECK_EN`: LW at 0x401 → no `bus_req`; `misaligned`=1 for one cycle; `stall` high for 1 cycle.
